fetch_sequencer: RTL and testbench

Instruction fetch and program-counter sequencer for the 10-bit CPU. It fetches one 10-bit instruction at a time from instruction memory over a request/valid handshake and presents it to the datapath, with the opcode field going to the control decoder. In the same cycle it samples the decoder's JUMP/BEQ/BNE/HALT outputs and the ALU zero flag to choose the next PC. It is the producer side of the decoder's OPCODE interface and the consumer of its sequencing outputs.

---
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer.sv | 88 ++++++++
 tb/tb_fetch_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory handshake, issue outputs and decoder feedback.
// master = sequencer side, slave = memory/decoder/datapath side.
interface fetch_sequencer_if #(
  parameter int PC_W = 10
);
  logic            IMEM_RD;
  logic [PC_W-1:0] IMEM_ADDR;
  logic [9:0]      IMEM_DATA;
  logic            IMEM_VALID;
  logic [9:0]      INSTR;
  logic [3:0]      OPCODE;
  logic            INSTR_VALID;
  logic            JUMP;
  logic            BEQ;
  logic            BNE;
  logic            HALT;
  logic            ZERO;
  logic            STALL;
  logic [PC_W-1:0] PC;
  logic            HALTED;

  modport master (
    output IMEM_RD, IMEM_ADDR, INSTR, OPCODE, INSTR_VALID, PC, HALTED,
    input  IMEM_DATA, IMEM_VALID, JUMP, BEQ, BNE, HALT, ZERO, STALL
  );

  modport slave (
    input  IMEM_RD, IMEM_ADDR, INSTR, OPCODE, INSTR_VALID, PC, HALTED,
    output IMEM_DATA, IMEM_VALID, JUMP, BEQ, BNE, HALT, ZERO, STALL
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer: FETCH -> WAIT -> ISSUE, with jump/branch/halt retire.
// Optional FETCH_RESUME_EN adds a RESUME input that restarts at PC+1 from HALTED.
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6
) (
  input  logic               CLK,
  input  logic               RESET,
`ifdef FETCH_RESUME_EN
  input  logic               RESUME,
`endif
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [9:0]      instr_q;
  logic            halted_q;

  logic [PC_W-1:0] offset_ext;
  logic            taken;
  logic [PC_W-1:0] pc_d;

  // Retire target; all additions wrap modulo 2^PC_W by width truncation.
  always_comb begin
    offset_ext = {{(PC_W-OFF_W){instr_q[OFF_W-1]}}, instr_q[OFF_W-1:0]};
    taken      = bus.JUMP | (bus.BEQ & bus.ZERO) | (bus.BNE & ~bus.ZERO);
    pc_d       = taken ? (pc_q + offset_ext) : (pc_q + PC_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      instr_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.IMEM_VALID) begin
            instr_q <= bus.IMEM_DATA;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // HALT outranks any branch; PC is left pointing at the halting instruction.
          if (!bus.STALL) begin
            if (bus.HALT) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
`ifdef FETCH_RESUME_EN
          if (RESUME) begin
            pc_q     <= pc_q + PC_W'(1);
            halted_q <= 1'b0;
            state_q  <= S_FETCH;
          end
`endif
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes decode from state, masked while RESET is held so they read as idle.
  assign bus.IMEM_RD     = (state_q == S_FETCH) & ~RESET;
  assign bus.INSTR_VALID = (state_q == S_ISSUE) & ~RESET;
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.OPCODE      = instr_q[9:6];
  assign bus.HALTED      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ISA-level PC model checked every cycle plus literal expectations.
module tb_fetch_sequencer;
  localparam int PC_W = 10;
  localparam logic [9:0] NOP = {4'd1, 6'd0};

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();
`ifdef FETCH_RESUME_EN
  logic RESUME = 1'b0;
`endif

  fetch_sequencer #(.PC_W(PC_W), .OFF_W(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
`ifdef FETCH_RESUME_EN
    .RESUME(RESUME),
`endif
    .bus   (bus)
  );

  // Bench decoder: 1 NOP, 2 JUMP, 3 BEQ, 4 BNE, 5 HALT, 6 HALT+JUMP.
  bit zero_v = 1'b0;
  assign bus.JUMP = (bus.OPCODE == 4'd2) || (bus.OPCODE == 4'd6);
  assign bus.BEQ  = (bus.OPCODE == 4'd3);
  assign bus.BNE  = (bus.OPCODE == 4'd4);
  assign bus.HALT = (bus.OPCODE == 4'd5) || (bus.OPCODE == 4'd6);
  assign bus.ZERO = zero_v;

  logic [9:0] mem [0:1023];
  int  lat = 0, stall_left = 0;
  bit  mem_auto = 1'b1;
  int  cyc = 0;
  int  nchk = 0, nerr = 0;
  int  rd_cyc[$], rd_addr[$], iv_cyc[$];
  int  m_pc = 0;
  bit  m_halted = 1'b0;
  bit  rd_q = 1'b0;
  int  addr_q = 0;
  bit  pend = 1'b0;
  int  cnt = 0, pa = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ISA-level next PC: returns new PC, h=1 when the instruction halts.
  function automatic int isa_next(input int pc, input logic [9:0] ins, input bit z, output bit h);
    int off;
    bit jmp, tk;
    int op;
    op  = int'(ins[9:6]);
    off = int'($signed(ins[5:0]));
    h   = (op == 5) || (op == 6);
    jmp = (op == 2) || (op == 6);
    tk  = jmp || (op == 3 && z) || (op == 4 && !z);
    if (h) return pc;
    return ((pc + (tk ? off : 1)) % 1024 + 1024) % 1024;
  endfunction

  always @(posedge CLK) cyc++;

  // Compare process: every cycle, DUT against the PC/halt model.
  always @(negedge CLK) begin
    bit h;
    int np;
    rd_q   = bus.IMEM_RD;
    addr_q = int'(bus.IMEM_ADDR);
    if (RESET) begin
      m_pc = 0;
      m_halted = 1'b0;
    end else begin
      if (bus.IMEM_RD) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(bus.IMEM_ADDR));
        chk("fetch_addr", int'(bus.IMEM_ADDR), m_pc);
      end
      if (bus.INSTR_VALID) begin
        iv_cyc.push_back(cyc);
        chk("issue_pc", int'(bus.PC), m_pc);
        chk("issue_instr", int'(bus.INSTR), int'(mem[m_pc]));
        chk("issue_opcode", int'(bus.OPCODE), int'(mem[m_pc][9:6]));
      end
      chk("halted", int'(bus.HALTED), int'(m_halted));
      if (m_halted) begin
        chk("halt_quiet", int'(bus.IMEM_RD | bus.INSTR_VALID), 0);
        chk("halt_pc", int'(bus.PC), m_pc);
`ifdef FETCH_RESUME_EN
        if (RESUME) begin
          m_pc = (m_pc + 1) % 1024;
          m_halted = 1'b0;
        end
`endif
      end else if (bus.INSTR_VALID && !bus.STALL) begin
        np = isa_next(m_pc, mem[m_pc], zero_v, h);
        m_pc = np;
        m_halted = h;
      end
    end
  end

  // Memory responder: data returns after lat empty WAIT cycles.
  always @(posedge CLK) begin
    #1;
    if (mem_auto) begin
      if (rd_q) begin
        pend = 1'b1;
        cnt  = lat;
        pa   = addr_q;
      end
      if (pend && cnt == 0) begin
        bus.IMEM_VALID = 1'b1;
        bus.IMEM_DATA  = mem[pa];
        pend = 1'b0;
      end else begin
        bus.IMEM_VALID = 1'b0;
        if (pend) cnt--;
      end
    end
  end

  // Datapath stall: first stall_left ISSUE cycles are stalled.
  always @(posedge CLK) begin
    #1;
    if (bus.INSTR_VALID && stall_left > 0) begin
      bus.STALL = 1'b1;
      stall_left--;
    end else begin
      bus.STALL = 1'b0;
    end
  end

  task automatic start(input int l, input int s, input bit z);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    mem_auto = 1'b1;
    lat = l;
    stall_left = s;
    zero_v = z;
    pend = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pc", int'(bus.PC), 0);
    chk("rst_instr", int'(bus.INSTR), 0);
    chk("rst_opcode", int'(bus.OPCODE), 0);
    chk("rst_rd", int'(bus.IMEM_RD), 0);
    chk("rst_ivalid", int'(bus.INSTR_VALID), 0);
    chk("rst_halted", int'(bus.HALTED), 0);
    rd_cyc.delete();
    rd_addr.delete();
    iv_cyc.delete();
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k;
    k = 0;
    while (rd_addr.size() < n && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    if (rd_addr.size() < n) chk("timeout_rd", rd_addr.size(), n);
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge CLK); while (cyc < n);
    #1;
  endtask

  initial begin
    bus.IMEM_VALID = 1'b0;
    bus.IMEM_DATA  = '0;
    bus.STALL      = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = NOP;

    // Back-to-back NOPs, zero-wait memory
    start(0, 0, 0);
    wait_cyc(8);
    chk("nop_rd_cyc0", rd_cyc[0], 1);
    chk("nop_rd_cyc1", rd_cyc[1], 4);
    chk("nop_rd_cyc2", rd_cyc[2], 7);
    chk("nop_rd_addr1", rd_addr[1], 1);
    chk("nop_rd_addr2", rd_addr[2], 2);
    chk("nop_iv_cyc0", iv_cyc[0], 3);
    chk("nop_iv_cyc1", iv_cyc[1], 6);

    // Two empty WAIT cycles per fetch
    start(2, 0, 0);
    wait_cyc(12);
    chk("lat2_iv_cyc0", iv_cyc[0], 5);
    chk("lat2_rd_cyc1", rd_cyc[1], 6);
    chk("lat2_rd_cyc2", rd_cyc[2], 11);

    // Backward jump at PC=5 by -2
    mem[5] = {4'd2, 6'b111110};
    start(0, 0, 0);
    wait_rd(7, 60);
    chk("jmp_back_from", rd_addr[5], 5);
    chk("jmp_back_to", rd_addr[6], 3);
    mem[5] = NOP;

    // 0 -4 wraps to 1020, then 1020 +5 wraps to 1
    mem[0]    = {4'd2, 6'b111100};
    mem[1020] = {4'd2, 6'd5};
    start(0, 0, 0);
    wait_rd(3, 40);
    chk("wrap_neg", rd_addr[1], 1020);
    chk("wrap_pos", rd_addr[2], 1);
    mem[0] = NOP;
    mem[1020] = NOP;

    // Conditional branches at PC=8, offset 4
    mem[0] = {4'd2, 6'd8};
    mem[8] = {4'd3, 6'd4};
    start(0, 0, 1);
    wait_rd(3, 40);
    chk("beq_taken", rd_addr[2], 12);
    start(0, 0, 0);
    wait_rd(3, 40);
    chk("beq_not_taken", rd_addr[2], 9);
    mem[8] = {4'd4, 6'd4};
    start(0, 0, 0);
    wait_rd(3, 40);
    chk("bne_taken", rd_addr[2], 12);
    start(0, 0, 1);
    wait_rd(3, 40);
    chk("bne_not_taken", rd_addr[2], 9);
    mem[8] = NOP;

    // HALT+JUMP at PC=7: halt wins
    mem[0] = {4'd2, 6'd7};
    mem[7] = {4'd6, 6'd3};
    mem[8] = {4'd5, 6'd0};
    start(0, 0, 0);
    wait_rd(2, 40);
    repeat (15) @(negedge CLK);
    #1;
    chk("halt_rd_count", rd_addr.size(), 2);
    chk("halt_flag", int'(bus.HALTED), 1);
    chk("halt_pc_lit", int'(bus.PC), 7);
`ifdef FETCH_RESUME_EN
    @(posedge CLK);
    #3;
    RESUME = 1'b1;
    @(posedge CLK);
    #3;
    RESUME = 1'b0;
    wait_rd(3, 20);
    chk("resume_addr", rd_addr[2], 8);
`endif
    mem[0] = NOP;
    mem[7] = NOP;
    mem[8] = NOP;

    // Three stalled ISSUE cycles on the first instruction
    start(0, 3, 0);
    wait_cyc(8);
    chk("stall_iv_len", iv_cyc.size(), 4);
    chk("stall_iv_last", iv_cyc[3], 6);
    chk("stall_rd_cyc1", rd_cyc[1], 7);
    chk("stall_rd_addr1", rd_addr[1], 1);

    // RESET while waiting at PC=9; a late valid in FETCH must be ignored
    mem[0] = {4'd2, 6'd9};
    start(0, 0, 0);
    wait_rd(2, 40);
    chk("rw_pre_addr", rd_addr[1], 9);
    mem_auto = 1'b0;
    bus.IMEM_VALID = 1'b0;
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    @(posedge CLK);
    #3;
    rd_cyc.delete();
    rd_addr.delete();
    iv_cyc.delete();
    RESET = 1'b0;
    cyc = 1;
    bus.IMEM_VALID = 1'b1;
    bus.IMEM_DATA  = {4'd2, 6'd7};
    @(posedge CLK);
    #3;
    bus.IMEM_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rw_rd_addr", rd_addr[0], 0);
    chk("rw_rd_cyc", rd_cyc[0], 1);
    chk("rw_no_issue", iv_cyc.size(), 0);
    chk("rw_ivalid", int'(bus.INSTR_VALID), 0);
    chk("rw_instr", int'(bus.INSTR), 0);
    mem[0] = NOP;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", nchk, nerr);
    $fatal(1);
  end

endmodule
